pong_ball_sched: RTL

//  Per-frame ball controller for vertical pong (paddles at top and bottom rows).
//  On each frame tick it steps ball position by its 4-bit vector and bounces off side walls.

---
 rtl/pong_ball_sched.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pong_ball_sched.sv
// pong_ball_sched: per-frame ball controller for vertical pong. Steps the ball on each frame
// tick, bounces it off the side walls and sequences paddle hits through an external vector calculator.
module pong_ball_sched #(
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int FIELD_W   = 640,
    parameter int FIELD_H   = 480,
    parameter int PADDLE_W  = 64,
    parameter int TOP_ROW   = 8,
    parameter int DOWN_ROW  = 472,
    parameter int STEP      = 2,
    parameter int CALC_LAT  = 1,
    parameter int MAX_SCORE = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           frame_tick,
    input  logic [X_W-1:0] paddle_top_x,
    input  logic [X_W-1:0] paddle_down_x,
    input  logic [3:0]     calc_result,
    output logic [2:0]     calc_player,
    output logic [3:0]     calc_vector,
    output logic [X_W-1:0] ball_x,
    output logic [Y_W-1:0] ball_y,
    output logic [3:0]     ball_vec,
    output logic [3:0]     score_top,
    output logic [3:0]     score_down,
    output logic           point_evt,
    output logic           game_over,
    output logic           tick_miss
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SERVE     = 3'd1,
        S_WAIT_TICK = 3'd2,
        S_MOVE      = 3'd3,
        S_CHECK     = 3'd4,
        S_CALC      = 3'd5,
        S_APPLY     = 3'd6,
        S_SCORE     = 3'd7
    } state_t;

    localparam int               CNT_W     = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
    localparam logic [X_W+1:0]   X_STEP    = (X_W+2)'(STEP);
    localparam logic [X_W+1:0]   X_MAX     = (X_W+2)'(FIELD_W - 1);
    localparam logic [Y_W+1:0]   Y_STEP    = (Y_W+2)'(STEP);
    localparam logic [Y_W+1:0]   Y_MAX     = (Y_W+2)'(FIELD_H - 1);
    localparam logic [X_W-1:0]   X_CENTRE  = X_W'(FIELD_W / 2);
    localparam logic [Y_W-1:0]   Y_CENTRE  = Y_W'(FIELD_H / 2);
    localparam logic [Y_W-1:0]   Y_TOP     = Y_W'(TOP_ROW);
    localparam logic [Y_W-1:0]   Y_DOWN    = Y_W'(DOWN_ROW);
    localparam logic [X_W:0]     SPAN      = (X_W+1)'(PADDLE_W - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CALC_LAT - 1);
    localparam logic [3:0]       SCORE_END = 4'(MAX_SCORE);
    localparam logic [3:0]       VEC_INIT  = 4'b0111;

    state_t           state_q, state_d;
    logic [X_W-1:0]   ball_x_q, ball_x_d;
    logic [Y_W-1:0]   ball_y_q, ball_y_d;
    logic [3:0]       ball_vec_q, ball_vec_d;
    logic [3:0]       score_top_q, score_top_d;
    logic [3:0]       score_down_q, score_down_d;
    logic [2:0]       calc_player_q, calc_player_d;
    logic [3:0]       calc_vector_q, calc_vector_d;
    logic             point_evt_q, point_evt_d;
    logic             game_over_q, game_over_d;
    logic             tick_miss_q, tick_miss_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             side_top_q, side_top_d;
    logic             serve_up_q, serve_up_d;

    logic [X_W+1:0]   x_sum;
    logic [Y_W+1:0]   y_sum;
    logic             at_top, at_down, top_hit, down_hit;
    logic [3:0]       score_inc;

    // Candidate positions and paddle-row tests; sums carry two spare bits so underflow shows in the MSB.
    always_comb begin
        case (ball_vec_q[3:2])
            2'b01:   x_sum = {2'b00, ball_x_q} + X_STEP;
            2'b10:   x_sum = {2'b00, ball_x_q} - X_STEP;
            default: x_sum = {2'b00, ball_x_q};
        endcase
        if (!ball_vec_q[0]) begin
            y_sum = {2'b00, ball_y_q};
        end else if (ball_vec_q[1]) begin
            y_sum = {2'b00, ball_y_q} - Y_STEP;
        end else begin
            y_sum = {2'b00, ball_y_q} + Y_STEP;
        end
        at_top    = ball_vec_q[1] && (ball_y_q <= Y_TOP);
        at_down   = !ball_vec_q[1] && (ball_y_q >= Y_DOWN);
        top_hit   = ({1'b0, ball_x_q} >= {1'b0, paddle_top_x}) &&
                    ({1'b0, ball_x_q} <= ({1'b0, paddle_top_x} + SPAN));
        down_hit  = ({1'b0, ball_x_q} >= {1'b0, paddle_down_x}) &&
                    ({1'b0, ball_x_q} <= ({1'b0, paddle_down_x} + SPAN));
        score_inc = side_top_q ? (score_down_q + 4'd1) : (score_top_q + 4'd1);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = start ? S_SERVE : S_IDLE;
            S_SERVE:     state_d = S_WAIT_TICK;
            S_WAIT_TICK: state_d = frame_tick ? S_MOVE : S_WAIT_TICK;
            S_MOVE:      state_d = S_CHECK;
            S_CHECK: begin
                if (at_top) begin
                    state_d = top_hit ? S_CALC : S_SCORE;
                end else if (at_down) begin
                    state_d = down_hit ? S_CALC : S_SCORE;
                end else begin
                    state_d = S_WAIT_TICK;
                end
            end
            S_CALC:      state_d = (cnt_q == '0) ? S_APPLY : S_CALC;
            S_APPLY:     state_d = S_WAIT_TICK;
            S_SCORE:     state_d = (score_inc == SCORE_END) ? S_IDLE : S_SERVE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath and output register inputs per state.
    always_comb begin
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        ball_vec_d    = ball_vec_q;
        score_top_d   = score_top_q;
        score_down_d  = score_down_q;
        calc_player_d = calc_player_q;
        calc_vector_d = calc_vector_q;
        point_evt_d   = 1'b0;
        game_over_d   = game_over_q;
        tick_miss_d   = frame_tick && (state_q != S_WAIT_TICK);
        cnt_d         = cnt_q;
        side_top_d    = side_top_q;
        serve_up_d    = serve_up_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    score_top_d  = 4'd0;
                    score_down_d = 4'd0;
                    game_over_d  = 1'b0;
                    serve_up_d   = 1'b1;
                end else begin
                    game_over_d  = game_over_q;
                end
            end
            S_SERVE: begin
                ball_x_d   = X_CENTRE;
                ball_y_d   = Y_CENTRE;
                ball_vec_d = {2'b01, serve_up_q, 1'b1};
            end
            S_MOVE: begin
                if (x_sum[X_W+1]) begin
                    ball_x_d        = '0;
                    ball_vec_d[3:2] = ~ball_vec_q[3:2];
                end else if (x_sum > X_MAX) begin
                    ball_x_d        = X_MAX[X_W-1:0];
                    ball_vec_d[3:2] = ~ball_vec_q[3:2];
                end else begin
                    ball_x_d        = x_sum[X_W-1:0];
                end
                if (y_sum[Y_W+1]) begin
                    ball_y_d = '0;
                end else if (y_sum > Y_MAX) begin
                    ball_y_d = Y_MAX[Y_W-1:0];
                end else begin
                    ball_y_d = y_sum[Y_W-1:0];
                end
            end
            S_CHECK: begin
                side_top_d = at_top;
                if ((at_top && top_hit) || (!at_top && at_down && down_hit)) begin
                    calc_player_d = at_top ? 3'd1 : 3'd2;
                    calc_vector_d = ball_vec_q;
                    cnt_d         = CNT_LOAD;
                end else begin
                    calc_player_d = 3'd0;
                end
            end
            S_CALC: begin
                if (cnt_q == '0) begin
                    calc_player_d = 3'd0;
                    calc_vector_d = 4'd0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_APPLY: begin
                // Vertical direction always points away from the paddle just hit.
                ball_vec_d = {calc_result[3:2], !side_top_q, 1'b1};
                ball_y_d   = side_top_q ? (Y_TOP + Y_W'(1)) : (Y_DOWN - Y_W'(1));
            end
            S_SCORE: begin
                point_evt_d = 1'b1;
                serve_up_d  = side_top_q;
                if (side_top_q) begin
                    score_down_d = score_inc;
                end else begin
                    score_top_d  = score_inc;
                end
                game_over_d = (score_inc == SCORE_END);
            end
            default: begin
                ball_x_d = ball_x_q;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ball_x_q      <= X_CENTRE;
            ball_y_q      <= Y_CENTRE;
            ball_vec_q    <= VEC_INIT;
            score_top_q   <= 4'd0;
            score_down_q  <= 4'd0;
            calc_player_q <= 3'd0;
            calc_vector_q <= 4'd0;
            point_evt_q   <= 1'b0;
            game_over_q   <= 1'b0;
            tick_miss_q   <= 1'b0;
            cnt_q         <= '0;
            side_top_q    <= 1'b0;
            serve_up_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            ball_vec_q    <= ball_vec_d;
            score_top_q   <= score_top_d;
            score_down_q  <= score_down_d;
            calc_player_q <= calc_player_d;
            calc_vector_q <= calc_vector_d;
            point_evt_q   <= point_evt_d;
            game_over_q   <= game_over_d;
            tick_miss_q   <= tick_miss_d;
            cnt_q         <= cnt_d;
            side_top_q    <= side_top_d;
            serve_up_q    <= serve_up_d;
        end
    end

    assign calc_player = calc_player_q;
    assign calc_vector = calc_vector_q;
    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign ball_vec    = ball_vec_q;
    assign score_top   = score_top_q;
    assign score_down  = score_down_q;
    assign point_evt   = point_evt_q;
    assign game_over   = game_over_q;
    assign tick_miss   = tick_miss_q;

endmodule
